// File: rtl/temporizador_pkg.sv
// Shared types and the agitation-load helper for the wash-cycle timer.
package temporizador_pkg;

   typedef enum logic [2:0] {
      OCIOSO   = 3'd0,
      AGITANDO = 3'd1,
      AGIT_FIM = 3'd2,
      GIRANDO  = 3'd3,
      GIRO_FIM = 3'd4
   } estado_t;

   typedef enum logic [1:0] {
      PROG_RAPIDO     = 2'd0,
      PROG_NORMAL     = 2'd1,
      PROG_PESADO     = 2'd2,
      PROG_NORMAL_ALT = 2'd3
   } programa_t;

   // Agitation duration in seconds for a wash program; the caller narrows it to its counter width.
   function automatic int unsigned carga_agitar(input logic [1:0] programa,
                                                input int unsigned t_agitar);
      case (programa_t'(programa))
         PROG_RAPIDO: return t_agitar / 2;
         PROG_PESADO: return 2 * t_agitar;
         default:     return t_agitar;
      endcase
   endfunction

endpackage

// File: rtl/temporizador_ciclo_divisor.sv
// Seconds prescaler: one-cycle tick every PRESCALE enabled clocks.
// With TEMPORIZADOR_ACELERADO_EN defined the prescaler is bypassed and every enabled clock ticks.
module divisor_segundos #(
   parameter int PRESCALE = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

`ifdef TEMPORIZADOR_ACELERADO_EN
   logic unused_ctl;
   assign unused_ctl = clk ^ rst ^ clr;
   assign tick       = en;
`else
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] RECARGA = PW'(PRESCALE - 1);

   logic [PW-1:0] presc_reg;

   // Holds while en is low, so a paused phase resumes mid-second without loss.
   always_ff @(posedge clk) begin
      if (!rst || clr) begin
         presc_reg <= RECARGA;
      end else if (en) begin
         presc_reg <= (presc_reg == '0) ? RECARGA : presc_reg - 1'b1;
      end
   end

   assign tick = en && (presc_reg == '0);
`endif

endmodule

// File: rtl/temporizador_ciclo.sv
// Agitation/spin timer feeding the washing-machine FSM (tempo, secar).
// Define TEMPORIZADOR_ACELERADO_EN to bypass the seconds prescaler.
module temporizador_ciclo
   import temporizador_pkg::*;
#(
   parameter int PRESCALE = 50_000_000,
   parameter int T_AGITAR = 600,
   parameter int T_GIRAR  = 300,
   parameter int CNT_W    = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             modo_agitar,
   input  logic             modo_girar,
   input  logic             porta_aberta,
   input  logic [1:0]       programa,
   output logic             tempo,
   output logic             secar,
   output logic [CNT_W-1:0] segundos_restantes,
   output logic             em_pausa
);

   localparam logic [CNT_W-1:0] CARGA_GIRAR = CNT_W'(T_GIRAR);

   estado_t          state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] carga_agit;
   logic             ativo, en, clr, tick, expira, ilegal, modo_caiu;

   assign ativo      = (state_reg == AGITANDO) || (state_reg == GIRANDO);
   assign en         = ativo && !porta_aberta;
   assign clr        = !ativo;
   assign ilegal     = modo_agitar && modo_girar;
   assign modo_caiu  = ((state_reg == AGITANDO) && !modo_agitar) ||
                       ((state_reg == GIRANDO)  && !modo_girar);
   // A zero load expires on the first running edge; otherwise on the tick that would take 1 to 0.
   assign expira     = en && ((cnt_reg == '0) || (tick && (cnt_reg == CNT_W'(1))));
   assign carga_agit = CNT_W'(carga_agitar(programa, T_AGITAR));

   divisor_segundos #(.PRESCALE(PRESCALE)) u_divisor (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .clr  (clr),
      .tick (tick)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg          <= OCIOSO;
         cnt_reg            <= '0;
         tempo              <= 1'b0;
         secar              <= 1'b1;
         segundos_restantes <= '0;
         em_pausa           <= 1'b0;
      end else begin
         tempo              <= 1'b0;
         secar              <= 1'b1;
         segundos_restantes <= '0;
         em_pausa           <= 1'b0;
         if (ilegal) begin
            state_reg <= OCIOSO;
            cnt_reg   <= '0;
         end else begin
            case (state_reg)
               OCIOSO: begin
                  if (modo_agitar) begin
                     state_reg          <= AGITANDO;
                     cnt_reg            <= carga_agit;
                     segundos_restantes <= carga_agit;
                  end else if (modo_girar) begin
                     state_reg          <= GIRANDO;
                     cnt_reg            <= CARGA_GIRAR;
                     segundos_restantes <= CARGA_GIRAR;
                  end
               end
               AGITANDO, GIRANDO: begin
                  if (modo_caiu) begin
                     state_reg <= OCIOSO;
                     cnt_reg   <= '0;
                  end else if (porta_aberta) begin
                     em_pausa           <= 1'b1;
                     segundos_restantes <= cnt_reg;
                  end else if (expira) begin
                     cnt_reg <= '0;
                     if (state_reg == AGITANDO) begin
                        state_reg <= AGIT_FIM;
                        tempo     <= 1'b1;
                     end else begin
                        state_reg <= GIRO_FIM;
                        secar     <= 1'b0;
                     end
                  end else if (tick) begin
                     cnt_reg            <= cnt_reg - 1'b1;
                     segundos_restantes <= cnt_reg - 1'b1;
                  end else begin
                     segundos_restantes <= cnt_reg;
                  end
               end
               AGIT_FIM: begin
                  if (!modo_agitar) begin
                     if (modo_girar) begin
                        state_reg          <= GIRANDO;
                        cnt_reg            <= CARGA_GIRAR;
                        segundos_restantes <= CARGA_GIRAR;
                     end else begin
                        state_reg <= OCIOSO;
                     end
                  end else begin
                     tempo <= 1'b1;
                  end
               end
               GIRO_FIM: begin
                  if (!modo_girar) begin
                     state_reg <= OCIOSO;
                  end else begin
                     secar <= 1'b0;
                  end
               end
               default: begin
                  state_reg <= OCIOSO;
                  cnt_reg   <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_temporizador_ciclo.sv
module tb_temporizador_ciclo;

`ifdef TEMPORIZADOR_ACELERADO_EN
    localparam int P = 1;
`else
    localparam int P = 4;
`endif
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             modo_agitar, modo_girar, porta_aberta;
    logic [1:0]       programa;
    logic             tempo, secar, em_pausa;
    logic [CNT_W-1:0] segundos_restantes;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    typedef struct {
        int    cyc;
        logic  tempo;
        logic  secar;
        int    seg;
        logic  pausa;
        string nome;
    } exp_t;

    exp_t sb[$];

    temporizador_ciclo #(
        .PRESCALE (4),
        .T_AGITAR (3),
        .T_GIRAR  (2),
        .CNT_W    (CNT_W)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .modo_agitar        (modo_agitar),
        .modo_girar         (modo_girar),
        .porta_aberta       (porta_aberta),
        .programa           (programa),
        .tempo              (tempo),
        .secar              (secar),
        .segundos_restantes (segundos_restantes),
        .em_pausa           (em_pausa)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push(input int c, input logic t, input logic s,
                                 input int seg, input logic p, input string nome);
        exp_t e;
        e.cyc = c; e.tempo = t; e.secar = s; e.seg = seg; e.pausa = p; e.nome = nome;
        sb.push_back(e);
    endfunction

    task automatic espera(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc <= cyc) begin
                    n_checks++;
                    if (sb[i].cyc == cyc && tempo === sb[i].tempo && secar === sb[i].secar &&
                        int'(segundos_restantes) == sb[i].seg && em_pausa === sb[i].pausa) begin
                        n_pass++;
                        $display("ok   %s @%0d tempo=%0b secar=%0b seg=%0d pausa=%0b",
                                 sb[i].nome, cyc, tempo, secar, segundos_restantes, em_pausa);
                    end else begin
                        $display("FAIL %s @%0d (want @%0d): got tempo=%0b secar=%0b seg=%0d pausa=%0b, want tempo=%0b secar=%0b seg=%0d pausa=%0b",
                                 sb[i].nome, cyc, sb[i].cyc, tempo, secar, segundos_restantes, em_pausa,
                                 sb[i].tempo, sb[i].secar, sb[i].seg, sb[i].pausa);
                    end
                    sb.delete(i);
                end
            end
        end
    end

    task automatic run_agit(input logic [1:0] prog, input int load, input bit mudar, input bit para_giro);
        int e0, g0;
        @(negedge clk);
        programa    = prog;
        modo_agitar = 1'b1;
        e0 = cyc + 1;
        push(e0, 1'b0, 1'b1, load, 1'b0, "agit_entrada");
        if (load > 1) push(e0 + P, 1'b0, 1'b1, load - 1, 1'b0, "agit_passo");
        push(e0 + load * P - 1, 1'b0, 1'b1, 1, 1'b0, "agit_ultimo");
        push(e0 + load * P, 1'b1, 1'b1, 0, 1'b0, "tempo_sobe");
        push(e0 + load * P + 1, 1'b1, 1'b1, 0, 1'b0, "tempo_mantem");
        if (mudar) begin
            espera(e0 + 1);
            programa = 2'd0;
        end
        espera(e0 + load * P + 1);
        modo_agitar = 1'b0;
        if (para_giro) begin
            modo_girar = 1'b1;
            g0 = cyc + 1;
            push(g0, 1'b0, 1'b1, 2, 1'b0, "agit_para_giro");
            push(g0 + 2 * P, 1'b0, 1'b0, 0, 1'b0, "giro_fim");
            espera(g0 + 2 * P);
            modo_girar = 1'b0;
            push(cyc + 1, 1'b0, 1'b1, 0, 1'b0, "giro_sai");
        end else begin
            push(cyc + 1, 1'b0, 1'b1, 0, 1'b0, "tempo_cai");
        end
        espera(cyc + 1);
    endtask

    initial begin
        int e0, s;
        rst = 1'b0; modo_agitar = 1'b0; modo_girar = 1'b0; porta_aberta = 1'b0; programa = 2'd1;
        repeat (2) @(negedge clk);
        modo_agitar = 1'b1;
        push(cyc + 1, 1'b0, 1'b1, 0, 1'b0, "reset");
        @(negedge clk);
        rst = 1'b1; modo_agitar = 1'b0;
        push(cyc + 1, 1'b0, 1'b1, 0, 1'b0, "ocioso");
        @(negedge clk);
        n_checks++;
        if (tempo === 1'b0 && secar === 1'b1 && segundos_restantes === '0 && em_pausa === 1'b0) begin
            n_pass++;
            $display("ok   ocioso_direto @%0d tempo=%0b secar=%0b seg=%0d pausa=%0b",
                     cyc, tempo, secar, segundos_restantes, em_pausa);
        end else begin
            $display("FAIL ocioso_direto @%0d: got tempo=%0b secar=%0b seg=%0d pausa=%0b",
                     cyc, tempo, secar, segundos_restantes, em_pausa);
        end

        run_agit(2'd1, 3, 1'b0, 1'b0);
        run_agit(2'd0, 1, 1'b0, 1'b0);
        run_agit(2'd2, 6, 1'b1, 1'b0);
        run_agit(2'd3, 3, 1'b0, 1'b1);

        @(negedge clk);
        modo_girar = 1'b1;
        e0 = cyc + 1;
        push(e0, 1'b0, 1'b1, 2, 1'b0, "giro_entrada");
        push(e0 + 2 * P - 1, 1'b0, 1'b1, 1, 1'b0, "secar_mantem");
        push(e0 + 2 * P, 1'b0, 1'b0, 0, 1'b0, "secar_cai");
        espera(e0 + 2 * P + 1);
        modo_girar = 1'b0;
        push(cyc + 1, 1'b0, 1'b1, 0, 1'b0, "secar_volta");
        espera(cyc + 1);

        @(negedge clk);
        programa = 2'd1; modo_agitar = 1'b1;
        e0 = cyc + 1;
        s  = e0 + P;
        push(s + 1, 1'b0, 1'b1, 2, 1'b1, "pausa");
        push(s + 10, 1'b0, 1'b1, 2, 1'b1, "pausa_fim");
        push(s + 11, 1'b0, 1'b1, 2, 1'b0, "retoma");
        push(e0 + 3 * P + 9, 1'b0, 1'b1, 1, 1'b0, "pausa_ultimo");
        push(e0 + 3 * P + 10, 1'b1, 1'b1, 0, 1'b0, "tempo_pausa");
        espera(s);
        porta_aberta = 1'b1;
        espera(s + 10);
        porta_aberta = 1'b0;
        espera(e0 + 3 * P + 10);
        modo_agitar = 1'b0;
        espera(cyc + 1);

        @(negedge clk);
        modo_girar = 1'b1;
        e0 = cyc + 1;
        push(e0 + P, 1'b0, 1'b1, 1, 1'b0, "giro_antes_rst");
        espera(e0 + P + 1);
        rst = 1'b0;
        push(cyc + 1, 1'b0, 1'b1, 0, 1'b0, "rst_meio");
        @(negedge clk);
        n_checks++;
        if (secar === 1'b1 && tempo === 1'b0 && segundos_restantes === '0 && em_pausa === 1'b0) begin
            n_pass++;
            $display("ok   rst_meio_direto @%0d tempo=%0b secar=%0b seg=%0d pausa=%0b",
                     cyc, tempo, secar, segundos_restantes, em_pausa);
        end else begin
            $display("FAIL rst_meio_direto @%0d: got tempo=%0b secar=%0b seg=%0d pausa=%0b",
                     cyc, tempo, secar, segundos_restantes, em_pausa);
        end
        rst = 1'b1; modo_girar = 1'b0;
        push(cyc + 1, 1'b0, 1'b1, 0, 1'b0, "pos_rst");
        @(negedge clk);
        n_checks++;
        if (tempo === 1'b0 && secar === 1'b1 && segundos_restantes === '0) begin
            n_pass++;
            $display("ok   pos_rst_direto @%0d tempo=%0b secar=%0b seg=%0d",
                     cyc, tempo, secar, segundos_restantes);
        end else begin
            $display("FAIL pos_rst_direto @%0d: got tempo=%0b secar=%0b seg=%0d",
                     cyc, tempo, secar, segundos_restantes);
        end

        modo_agitar = 1'b1; modo_girar = 1'b1; programa = 2'd1;
        push(cyc + 1, 1'b0, 1'b1, 0, 1'b0, "ilegal");
        push(cyc + 4, 1'b0, 1'b1, 0, 1'b0, "ilegal_mant");
        espera(cyc + 4);
        modo_girar = 1'b0;
        e0 = cyc + 1;
        push(e0, 1'b0, 1'b1, 3, 1'b0, "sai_ilegal");
        espera(e0);
        modo_girar = 1'b1;
        push(cyc + 1, 1'b0, 1'b1, 0, 1'b0, "ilegal_meio");
        espera(cyc + 1);
        modo_agitar = 1'b0; modo_girar = 1'b0;

        for (int k = 0; k < 50 && sb.size() > 0; k++) @(negedge clk);
        while (sb.size() > 0) begin
            n_checks++;
            $display("FAIL %s: expectation @%0d never checked", sb[0].nome, sb[0].cyc);
            void'(sb.pop_front());
        end
        if (n_pass == n_checks) begin
            $display("PASS %0d/%0d checks passed", n_pass, n_checks);
        end else begin
            $display("FAIL %0d/%0d checks passed", n_pass, n_checks);
        end
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1, "timeout");
    end

endmodule
